// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding and requester port identifiers.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

endpackage

// File: rtl/mem_arb2.sv
// Two-way requester arbiter. Fixed priority (mem wins) by default;
// round-robin with a last-grant flop when MEMCTRL_FAIR_ARB_EN is defined.
module mem_arb2
    import mem_pkg::*;
(
`ifdef MEMCTRL_FAIR_ARB_EN
    input  logic clk_i,
    input  logic rst_ni,
    input  logic accept_i,
`endif
    input  logic if_req_i,
    input  logic mem_req_i,
    output logic valid_o,
    output logic gnt_o
);

    assign valid_o = if_req_i | mem_req_i;

`ifdef MEMCTRL_FAIR_ARB_EN
    logic last_q;

    // On a tie, hand the grant to whichever port was not served last.
    always_comb begin
        gnt_o = mem_req_i ? PORT_MEM : PORT_IF;
        if (if_req_i && mem_req_i) begin
            gnt_o = (last_q == PORT_IF) ? PORT_MEM : PORT_IF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= PORT_IF;
        end else if (accept_i && valid_o) begin
            last_q <= gnt_o;
        end
    end
`else
    assign gnt_o = mem_req_i ? PORT_MEM : PORT_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one narrow SRAM, moving each word as
// BEATS RAM beats MSB-half first. Build option: MEMCTRL_FAIR_ARB_EN (round-robin).
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int RAM_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we_n,
    output logic [RAM_W-1:0]  ram_wdata,
    output logic              ram_oe,
    input  logic [RAM_W-1:0]  ram_rdata
);

    localparam int BEATS = DATA_W / RAM_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(BEATS - 1);

    function automatic logic [RAM_W-1:0] slice(input logic [DATA_W-1:0] w, input logic [BW-1:0] b);
        return RAM_W'(w >> ((BEATS - 1 - int'(b)) * RAM_W));
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w,
                                                 input logic [RAM_W-1:0]  d,
                                                 input logic [BW-1:0]     b);
        logic [DATA_W-1:0] r;
        r = w;
        for (int i = 0; i < BEATS; i++) begin
            if (i == int'(b)) r[DATA_W-1-i*RAM_W -: RAM_W] = d;
        end
        return r;
    endfunction

    state_e            state_q;
    logic [BW-1:0]     beat_q;
    logic              port_q, we_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q, if_rdata_q, mem_rdata_q;
    logic              if_done_q, mem_done_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_n_q, ram_oe_q;
    logic [RAM_W-1:0]  ram_wdata_q;

    logic              arb_valid, arb_gnt;
    logic              we_d;
    logic [ADDR_W-1:0] base_d;
    logic [DATA_W-1:0] wdata_d;
    logic [BW-1:0]     beat_d;

    mem_arb2 u_arb (
`ifdef MEMCTRL_FAIR_ARB_EN
        .clk_i     (clock),
        .rst_ni    (reset),
        .accept_i  (state_q == ST_IDLE),
`endif
        .if_req_i  (if_req),
        .mem_req_i (mem_req),
        .valid_o   (arb_valid),
        .gnt_o     (arb_gnt)
    );

    // The fetch port is read-only, so write intent only comes from a mem grant.
    assign we_d    = (arb_gnt == PORT_MEM) && mem_we;
    assign base_d  = ((arb_gnt == PORT_MEM) ? mem_addr : if_addr) & ALIGN_MSK;
    assign wdata_d = mem_wdata;
    assign beat_d  = BW'(beat_q + 1'b1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            port_q      <= PORT_IF;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_n_q  <= 1'b1;
            ram_oe_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        port_q     <= arb_gnt;
                        we_q       <= we_d;
                        base_q     <= base_d;
                        wdata_q    <= wdata_d;
                        beat_q     <= '0;
                        ram_addr_q <= base_d;
                        ram_we_n_q <= ~we_d;
                        ram_oe_q   <= we_d;
                        if (we_d) ram_wdata_q <= slice(wdata_d, '0);
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // RAM is combinational, so the current beat's data is on ram_rdata now.
                    if (!we_q) begin
                        if (port_q == PORT_MEM) mem_rdata_q <= merge(mem_rdata_q, ram_rdata, beat_q);
                        else                    if_rdata_q  <= merge(if_rdata_q, ram_rdata, beat_q);
                    end
                    if (beat_q == LAST_BEAT) begin
                        ram_we_n_q <= 1'b1;
                        ram_oe_q   <= 1'b0;
                        if_done_q  <= (port_q == PORT_IF);
                        mem_done_q <= (port_q == PORT_MEM);
                        state_q    <= ST_DONE;
                    end else begin
                        beat_q     <= beat_d;
                        ram_addr_q <= base_q | ADDR_W'(beat_d);
                        if (we_q) ram_wdata_q <= slice(wdata_q, beat_d);
                    end
                end
                default: begin
                    beat_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we_n  = ram_we_n_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_oe    = ram_oe_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small combinational RAM model.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, mem_req, mem_we;
    logic [17:0] if_addr, mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_done, mem_done;
    logic [17:0] ram_addr;
    logic        ram_we_n, ram_oe;
    logic [15:0] ram_wdata, ram_rdata;

    logic [15:0] ram [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    int          wr_count = 0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_we_n  (ram_we_n),
        .ram_wdata (ram_wdata),
        .ram_oe    (ram_oe),
        .ram_rdata (ram_rdata)
    );

    always #5 clock = ~clock;

    assign ram_rdata = ram[ram_addr[9:0]];

    always @(posedge clock) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (!ram_we_n) begin
            ram[ram_addr[9:0]] <= ram_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clock);
        pl_en   = 1'b0;
    endtask

    // Counts falling edges until the selected done pulse is seen (bounded).
    task automatic wait_done(input bit sel_mem, output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!(sel_mem ? mem_done : if_done) && cyc < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        int wc;
        int pulses;
        bit seq [0:3];

        reset = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        @(negedge clock);
        preload(10'h102, 16'hDEAD);
        preload(10'h103, 16'hBEEF);
        preload(10'h300, 16'h0000);
        preload(10'h301, 16'h0000);

        chk("rst_ram_we_n", 32'(ram_we_n), 32'd1);
        chk("rst_ram_oe", 32'(ram_oe), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);

        reset = 1'b1;
        @(negedge clock);

        // Fetch read of 0x102/0x103.
        if_req = 1'b1; if_addr = 18'h00102;
        @(negedge clock);
        chk("fetch_b0_addr", 32'(ram_addr), 32'h102);
        chk("fetch_b0_we_n", 32'(ram_we_n), 32'd1);
        wait_done(1'b0, c);
        chk("fetch_latency", c + 1, 32'd3);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        @(negedge clock);
        chk("fetch_done_pulse", 32'(if_done), 32'd0);

        // Data read, so mem_rdata holds a known value before the write.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00103;
        wait_done(1'b1, c);
        chk("mread_latency", c, 32'd3);
        chk("mread_rdata", mem_rdata, 32'hDEADBEEF);
        mem_req = 1'b0;
        @(negedge clock);

        // Data write to unaligned 0x201 lands on 0x200/0x201.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00201; mem_wdata = 32'h12345678;
        @(negedge clock);
        chk("wr_b0_addr", 32'(ram_addr), 32'h200);
        chk("wr_b0_we_n", 32'(ram_we_n), 32'd0);
        chk("wr_b0_oe", 32'(ram_oe), 32'd1);
        chk("wr_b0_wdata", 32'(ram_wdata), 32'h1234);
        @(negedge clock);
        chk("wr_b1_addr", 32'(ram_addr), 32'h201);
        chk("wr_b1_wdata", 32'(ram_wdata), 32'h5678);
        chk("wr_b1_we_n", 32'(ram_we_n), 32'd0);
        @(negedge clock);
        chk("wr_done", 32'(mem_done), 32'd1);
        chk("wr_done_we_n", 32'(ram_we_n), 32'd1);
        chk("wr_done_oe", 32'(ram_oe), 32'd0);
        chk("wr_ram200", 32'(ram[10'h200]), 32'h1234);
        chk("wr_ram201", 32'(ram[10'h201]), 32'h5678);
        chk("wr_mem_rdata_kept", mem_rdata, 32'hDEADBEEF);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clock);
        chk("wr_done_pulse", 32'(mem_done), 32'd0);

        // Fetch request dropped during XFER still completes exactly once.
        if_req = 1'b1; if_addr = 18'h00200;
        @(negedge clock);
        if_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (if_done) pulses++;
        end
        chk("drop_pulses", pulses, 32'd1);
        chk("drop_rdata", if_rdata, 32'h12345678);
        chk("drop_idle_we_n", 32'(ram_we_n), 32'd1);

        // Fresh reset so the arbitration history is known.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

`ifdef MEMCTRL_FAIR_ARB_EN
        if_req = 1'b1; if_addr = 18'h00102;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00200;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clock);
            if (mem_done) begin seq[n] = 1'b1; n++; end
            if (if_done)  begin seq[n] = 1'b0; n++; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        chk("rr_count", n, 32'd4);
        chk("rr_g0_mem", 32'(seq[0]), 32'd1);
        chk("rr_g1_if", 32'(seq[1]), 32'd0);
        chk("rr_g2_mem", 32'(seq[2]), 32'd1);
        chk("rr_g3_if", 32'(seq[3]), 32'd0);
        repeat (6) @(negedge clock);
`else
        // Mem wins the tie; fetch is granted in the IDLE cycle after mem's DONE,
        // so its done arrives BEATS+2 = 4 cycles after mem_done.
        if_req = 1'b1; if_addr = 18'h00200;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00102;
        wait_done(1'b1, c);
        chk("tie_mem_latency", c, 32'd3);
        chk("tie_if_not_done", 32'(if_done), 32'd0);
        chk("tie_mem_rdata", mem_rdata, 32'hDEADBEEF);
        mem_req = 1'b0;
        wait_done(1'b0, c);
        chk("tie_if_after_mem", c, 32'd4);
        chk("tie_if_rdata", if_rdata, 32'h12345678);
        if_req = 1'b0;
        @(negedge clock);
`endif
        n = 0;

        // Reset asserted during write beat 0 abandons the write.
        wc = wr_count;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00300; mem_wdata = 32'hA5A55A5A;
        @(negedge clock);
        chk("rstw_b0_we_n", 32'(ram_we_n), 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        reset = 1'b0;
        #1;
        chk("rstw_we_n", 32'(ram_we_n), 32'd1);
        chk("rstw_oe", 32'(ram_oe), 32'd0);
        chk("rstw_done", 32'(mem_done), 32'd0);
        chk("rstw_addr", 32'(ram_addr), 32'd0);
        chk("rstw_wdata", 32'(ram_wdata), 32'd0);
        repeat (3) @(negedge clock);
        chk("rstw_ram300", 32'(ram[10'h300]), 32'h0000);
        chk("rstw_wr_count", wr_count - wc, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rstw_idle_we_n", 32'(ram_we_n), 32'd1);
        chk("rstw_idle_done", {30'd0, if_done, mem_done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
